// File: rtl/csa_mw_sequencer.sv
// Multi-word add/subtract sequencer: streams a wide operand pair through a shared
// 32-bit combinational carry-select adder, least-significant word first.
//
// state | meaning
// IDLE  | ready for a request, add_* outputs parked at zero
// RUN   | one word per cycle through the CSA, carry chained in a register
// DONE  | wide result presented, held until the consumer accepts it
module csa_mw_sequencer #(
    parameter int NWORDS = 4,
    parameter int IDXW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [32*NWORDS-1:0] req_a,
    input  logic [32*NWORDS-1:0] req_b,
    input  logic                 req_cin,
    input  logic                 req_sub,
    input  logic                 flush,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [32*NWORDS-1:0] res_sum,
    output logic                 res_cout,
    output logic                 res_ovf,
    output logic                 busy
);

    localparam int W = 32 * NWORDS;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            last_word;

    assign last_word = (idx == IDXW'(NWORDS - 1));
    assign res_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = op_a[idx*32 +: 32];
            add_b   = op_b[idx*32 +: 32];
            add_cin = carry;
        end
    end

    // req_ready is registered so it only rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            carry     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        op_a      <= req_a;
                        op_b      <= req_sub ? ~req_b : req_b;
                        carry     <= req_sub ? 1'b1 : req_cin;
                        idx       <= '0;
                        state     <= S_RUN;
                        req_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    res_sum[idx*32 +: 32] <= add_sum;
                    carry                 <= add_cout;
                    idx                   <= idx + IDXW'(1);
                    if (last_word) begin
                        res_cout <= add_cout;
                        // overflow: like-signed operands yielding an opposite-signed result
                        res_ovf  <= (op_a[W-1] == op_b[W-1]) && (add_sum[31] != op_a[W-1]);
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mw_sequencer.sv
// Directed bench for csa_mw_sequencer (NWORDS=4) with a behavioural 32-bit adder
// standing in for the external carry-select adder.
module tb_csa_mw_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         req_cin;
    logic         req_sub;
    logic         flush;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_sum;
    logic         add_cout;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_sum;
    logic         res_cout;
    logic         res_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    csa_mw_sequencer #(.NWORDS(4), .IDXW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .flush(flush),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
        .busy(busy)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [127:0] a, input logic [127:0] b,
                             input logic cin, input logic sub);
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        chk("ready_before_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", req_ready, 0);
    endtask

    // Walks the RUN words, checking what is driven to the adder each cycle.
    task automatic run_words(input logic [127:0] a, input logic [127:0] b,
                             input logic cin, input logic sub);
        logic        c;
        logic [31:0] wa, wb;
        logic [32:0] s;
        c = sub ? 1'b1 : cin;
        for (int k = 0; k < 4; k++) begin
            wa = a[k*32 +: 32];
            wb = sub ? ~b[k*32 +: 32] : b[k*32 +: 32];
            chk($sformatf("add_a_w%0d", k), add_a, wa);
            chk($sformatf("add_b_w%0d", k), add_b, wb);
            chk($sformatf("add_cin_w%0d", k), add_cin, c);
            chk($sformatf("res_valid_low_w%0d", k), res_valid, 0);
            s = {1'b0, wa} + {1'b0, wb} + {32'd0, c};
            c = s[32];
            tick();
        end
        chk("res_valid_after_n", res_valid, 1);
        chk("add_a_parked", add_a, 0);
    endtask

    task automatic check_res(input string tag, input logic [127:0] sum,
                             input logic cout, input logic ovf);
        chk({tag, "_sum"}, res_sum, sum);
        chk({tag, "_cout"}, res_cout, cout);
        chk({tag, "_ovf"}, res_ovf, ovf);
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("ready_after_handshake", req_ready, 1);
        chk("busy_idle", busy, 0);
    endtask

    logic [127:0] a4, b4, s4, held;

    initial begin
        a4 = 128'h12345678_DEADBEEF_AAAAAAAA_FFFFFFFF;
        b4 = 128'h87654321_12345678_55555555_00000001;
        s4 = 128'h99999999_F0E21568_00000000_00000001;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_cin = 1'b0; req_sub = 1'b0; flush = 1'b0; res_ready = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_add_a", add_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_low_before_edge", req_ready, 0);
        tick();
        chk("ready_first_edge", req_ready, 1);

        // all-ones + 1: carry ripples through every word
        start_req({128{1'b1}}, 128'd1, 1'b0, 1'b0);
        run_words({128{1'b1}}, 128'd1, 1'b0, 1'b0);
        check_res("t1", 128'd0, 1'b1, 1'b0);
        finish_res();
        chk("t1_sum_kept", res_sum, 0);
        chk("t1_cout_kept", res_cout, 1);

        // 0 - 1 borrows
        start_req(128'd0, 128'd1, 1'b0, 1'b1);
        run_words(128'd0, 128'd1, 1'b0, 1'b1);
        check_res("t2", {128{1'b1}}, 1'b0, 1'b0);
        finish_res();

        // max positive + 1 overflows
        start_req({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
        run_words({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
        check_res("t3", {1'b1, 127'd0}, 1'b0, 1'b1);
        finish_res();

        // mixed pattern with carry-in, then held in DONE with a competing request
        start_req(a4, b4, 1'b1, 1'b0);
        run_words(a4, b4, 1'b1, 1'b0);
        check_res("t4", s4, 1'b0, 1'b0);
        req_a = 128'd5; req_b = 128'd3; req_cin = 1'b0; req_sub = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_sum", res_sum, s4);
            chk("hold_req_ready", req_ready, 0);
        end
        finish_res();
        tick();
        chk("accept_after_handshake", busy, 1);
        req_valid = 1'b0;
        run_words(128'd5, 128'd3, 1'b0, 1'b0);
        check_res("t5", 128'd8, 1'b0, 1'b0);
        finish_res();

        // asynchronous reset while idx=2
        start_req(a4, b4, 1'b0, 1'b0);
        tick();
        tick();
        chk("mid_run_add_a_w2", add_a, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_sum", res_sum, 0);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_cout", res_cout, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_mid_rst", req_ready, 1);
        start_req(a4, b4, 1'b1, 1'b0);
        run_words(a4, b4, 1'b1, 1'b0);
        check_res("t6", s4, 1'b0, 1'b0);
        finish_res();

        // flush at idx=1 with a request presented in the same cycle
        start_req(128'd7, 128'd2, 1'b0, 1'b1);
        tick();
        held = {s4[127:32], 32'd5};
        flush = 1'b1; req_valid = 1'b1; req_a = 128'd1; req_b = 128'd1;
        req_sub = 1'b0;
        chk("flush_cycle_ready", req_ready, 0);
        tick();
        chk("flush_busy", busy, 0);
        chk("flush_res_valid", res_valid, 0);
        chk("flush_sum_kept", res_sum, held);
        chk("flush_ready_idle", req_ready, 1);
        // flush while idle also drops the request
        tick();
        chk("flush_idle_drop", busy, 0);
        flush = 1'b0; req_valid = 1'b0;
        start_req(a4, b4, 1'b1, 1'b0);
        run_words(a4, b4, 1'b1, 1'b0);
        check_res("t7", s4, 1'b0, 1'b0);
        finish_res();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
